// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: compares each resolved branch with its
// fetch-time prediction, issues one registered redirect/flush to fetch
// (after the delay slot has issued), and queues predictor training records
// in a small FIFO drained by the BPU.
module branch_redirect_ctrl #(
    parameter int unsigned UPD_DEPTH  = 4,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    input  logic                  res_taken,
    input  logic [31:0]           res_target,
    input  logic [31:0]           br_pc,
    input  logic                  pred_taken,
    input  logic [31:0]           pred_target,
    input  logic                  ds_present,
    input  logic                  ds_issue,
    input  logic                  flush_in,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  flush_front,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [31:0]           upd_pc,
    output logic [31:0]           upd_target,
    output logic                  upd_taken,
    output logic                  upd_mispredict,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(UPD_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DS,
        REDIRECT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        mis;
    } upd_rec_t;

    state_t      state;
    logic [31:0] pend_pc;

    logic        mis;
    logic [31:0] correct_pc;
    logic        accept;

    upd_rec_t    fifo_mem [UPD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic        full;
    logic        pop;
    logic        do_push;
    upd_rec_t    head;

    // Resolution decode: mispredict flag, architecturally correct next PC,
    // and FIFO handshake qualifiers.
    always_comb begin
        mis        = (res_taken != pred_taken) | (res_taken & (res_target != pred_target));
        correct_pc = res_taken ? res_target : (br_pc + 32'd8);
        accept     = res_valid & ~flush_in;
        full       = (count == CNT_W'(UPD_DEPTH));
        pop        = upd_valid & upd_ready;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        do_push    = accept & (~full | pop);
    end

    // Redirect FSM with registered strobe and PC; flush_in overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            pend_pc        <= '0;
        end else begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            if (flush_in) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (res_valid && mis) begin
                            pend_pc <= correct_pc;
                            if (ds_present) begin
                                state          <= REDIRECT;
                                redirect_valid <= 1'b1;
                                redirect_pc    <= correct_pc;
                            end else begin
                                state <= WAIT_DS;
                            end
                        end
                    end
                    WAIT_DS: begin
                        if (ds_issue) begin
                            state          <= REDIRECT;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= pend_pc;
                        end
                    end
                    REDIRECT: state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    assign flush_front = redirect_valid;

    // Update FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= '{pc: br_pc, target: res_target, taken: res_taken, mis: mis};
        end
    end

    // Update FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && pop) begin
                count <= count - CNT_W'(1);
            end
            if (accept && full && !pop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // Head presentation, forced to zero while the FIFO is empty.
    always_comb begin
        upd_valid      = (count != '0);
        head           = fifo_mem[rd_ptr];
        upd_pc         = upd_valid ? head.pc : '0;
        upd_target     = upd_valid ? head.target : '0;
        upd_taken      = upd_valid & head.taken;
        upd_mispredict = upd_valid & head.mis;
    end

endmodule
